data_sram_confreg: RTL and testbench

Responder for the CPU core's data SRAM port: accepts the one-request-per-cycle `data_sram_*` interface and returns read data with fixed one-cycle latency. Addresses are decoded into a byte-writable on-chip RAM and a small configuration-register window. The window holds LED, switch, numeric-display, scratch and timer registers. The block sits at the top level beside the core, on the far side of `data_sram_en/wen/addr/wdata/rdata`.

---
 rtl/data_sram_confreg.sv | 171 +++++++++++++++++
 tb/tb_data_sram_confreg.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/data_sram_confreg.sv
// Data-SRAM-port responder: byte-writable RAM plus LED/switch/NUM/scratch/timer register window.
// Optional TIMER register at offset 0x0010 is built only when CONFREG_TIMER_EN is defined.
module data_sram_confreg #(
   parameter int          RAM_AW    = 14,
   parameter logic [31:0] CONF_BASE = 32'hbfaf_0000
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        data_sram_en,
   input  logic [3:0]  data_sram_wen,
   input  logic [31:0] data_sram_addr,
   input  logic [31:0] data_sram_wdata,
   output logic [31:0] data_sram_rdata,
   input  logic [7:0]  switch,
   output logic [15:0] led,
   output logic [31:0] num_data
);

   typedef enum logic [2:0] {
      REG_LED,
      REG_SWITCH,
      REG_NUM,
      REG_SCRATCH,
      REG_TIMER,
      REG_NONE
   } reg_sel_e;

   localparam int RAM_DEPTH = 1 << RAM_AW;

   // Byte-lane merge shared by RAM and every writable register.
   function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  lanes);
      logic [31:0] res;
      res = old_val;
      for (int i = 0; i < 4; i++) begin
         if (lanes[i]) res[8*i +: 8] = new_val[8*i +: 8];
      end
      return res;
   endfunction

   logic              conf_hit;
   logic [RAM_AW-1:0] ram_idx;
   logic              ram_access;
   logic              conf_write;
   reg_sel_e          reg_sel;
   logic [31:0]       conf_rd;
   logic [31:0]       timer_rd;

   assign conf_hit   = data_sram_addr[31:16] == CONF_BASE[31:16];
   assign ram_idx    = data_sram_addr[RAM_AW+1:2];
   assign ram_access = data_sram_en && !conf_hit;
   assign conf_write = data_sram_en && conf_hit && (data_sram_wen != 4'h0);

   // ------------------------------------------------------------------ RAM
   logic [31:0] ram [RAM_DEPTH];
   logic [31:0] ram_q;

   // NOTE: RAM and its read register carry no reset so they map onto block RAM;
   // the output mux below hides ram_q until the first RAM read after reset.
   always_ff @(posedge clk) begin
      if (ram_access) begin
         ram_q <= ram[ram_idx];
         for (int i = 0; i < 4; i++) begin
            if (data_sram_wen[i]) ram[ram_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
         end
      end
   end

   // ------------------------------------------------------------ confregs
   logic [7:0]  switch_meta;
   logic [7:0]  switch_sync;
   logic [15:0] led_q;
   logic [31:0] num_q;
   logic [31:0] scratch_q;

   // NOTE: defaults first so every path assigns reg_sel and no latch is inferred.
   always_comb begin
      reg_sel = REG_NONE;
      case (data_sram_addr[15:0])
         16'h0000: reg_sel = REG_LED;
         16'h0004: reg_sel = REG_SWITCH;
         16'h0008: reg_sel = REG_NUM;
         16'h000c: reg_sel = REG_SCRATCH;
`ifdef CONFREG_TIMER_EN
         16'h0010: reg_sel = REG_TIMER;
`endif
         default:  reg_sel = REG_NONE;
      endcase
   end

   always_comb begin
      conf_rd = 32'h0;
      case (reg_sel)
         REG_LED:     conf_rd = {16'h0, led_q};
         REG_SWITCH:  conf_rd = {24'h0, switch_sync};
         REG_NUM:     conf_rd = num_q;
         REG_SCRATCH: conf_rd = scratch_q;
         REG_TIMER:   conf_rd = timer_rd;
         default:     conf_rd = 32'h0;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         switch_meta <= 8'h0;
         switch_sync <= 8'h0;
      end else begin
         switch_meta <= switch;
         switch_sync <= switch_meta;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         led_q     <= 16'h0;
         num_q     <= 32'h0;
         scratch_q <= 32'h0;
      end else if (conf_write) begin
         case (reg_sel)
            REG_LED:     led_q     <= merge_bytes({16'h0, led_q}, data_sram_wdata, data_sram_wen)
                                      & 32'h0000_ffff;
            REG_NUM:     num_q     <= merge_bytes(num_q, data_sram_wdata, data_sram_wen);
            REG_SCRATCH: scratch_q <= merge_bytes(scratch_q, data_sram_wdata, data_sram_wen);
            default:     ;
         endcase
      end
   end

`ifdef CONFREG_TIMER_EN
   logic [31:0] timer_q;
   logic [31:0] timer_inc;

   assign timer_inc = timer_q + 32'd1;
   assign timer_rd  = timer_q;

   // Written bytes load; unwritten bytes keep counting.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         timer_q <= 32'h0;
      end else if (conf_write && reg_sel == REG_TIMER) begin
         timer_q <= merge_bytes(timer_inc, data_sram_wdata, data_sram_wen);
      end else begin
         timer_q <= timer_inc;
      end
   end
`else
   assign timer_rd = 32'h0;
`endif

   // ------------------------------------------------------------ read data
   logic        rd_from_ram;
   logic [31:0] conf_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rd_from_ram <= 1'b0;
         conf_q      <= 32'h0;
      end else if (data_sram_en) begin
         rd_from_ram <= !conf_hit;
         if (conf_hit) conf_q <= conf_rd;
      end
   end

   assign data_sram_rdata = rd_from_ram ? ram_q : conf_q;
   assign led             = led_q;
   assign num_data        = num_q;

endmodule

// File: tb/tb_data_sram_confreg.sv
// Directed self-checking bench for data_sram_confreg; timer checks follow CONFREG_TIMER_EN.
module tb_data_sram_confreg;

   logic        clk;
   logic        resetn;
   logic        data_sram_en;
   logic [3:0]  data_sram_wen;
   logic [31:0] data_sram_addr;
   logic [31:0] data_sram_wdata;
   logic [31:0] data_sram_rdata;
   logic [7:0]  switch;
   logic [15:0] led;
   logic [31:0] num_data;

   int checks = 0;
   int errors = 0;

   localparam logic [31:0] A_LED     = 32'hbfaf_0000;
   localparam logic [31:0] A_SWITCH  = 32'hbfaf_0004;
   localparam logic [31:0] A_NUM     = 32'hbfaf_0008;
   localparam logic [31:0] A_SCRATCH = 32'hbfaf_000c;
   localparam logic [31:0] A_TIMER   = 32'hbfaf_0010;
   localparam logic [31:0] A_UNMAP   = 32'hbfaf_0100;

   data_sram_confreg dut (
      .clk             (clk),
      .resetn          (resetn),
      .data_sram_en    (data_sram_en),
      .data_sram_wen   (data_sram_wen),
      .data_sram_addr  (data_sram_addr),
      .data_sram_wdata (data_sram_wdata),
      .data_sram_rdata (data_sram_rdata),
      .switch          (switch),
      .led             (led),
      .num_data        (num_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drives one request, lets one rising edge pass, returns 1 time unit after it.
   task automatic cycle(input logic e, input logic [3:0] w,
                        input logic [31:0] a, input logic [31:0] d);
      data_sram_en    = e;
      data_sram_wen   = w;
      data_sram_addr  = a;
      data_sram_wdata = d;
      @(posedge clk);
      #1;
      data_sram_en  = 1'b0;
      data_sram_wen = 4'h0;
   endtask

   task automatic test_reset;
      #3;
      checks++; if (data_sram_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want %h", data_sram_rdata, 32'h0); end
      checks++; if (led !== 16'h0) begin errors++; $display("FAIL reset_led: got %h want %h", led, 16'h0); end
      checks++; if (num_data !== 32'h0) begin errors++; $display("FAIL reset_num: got %h want %h", num_data, 32'h0); end
      @(posedge clk);
      #1;
      resetn = 1'b1;
   endtask

   task automatic test_ram_bytes;
      cycle(1'b1, 4'hf, 32'h0000_0100, 32'h1122_3344);
      cycle(1'b1, 4'b0010, 32'h0000_0100, 32'h0000_aa00);
      checks++; if (data_sram_rdata !== 32'h1122_3344) begin errors++; $display("FAIL ram_byte_prewrite: got %h want %h", data_sram_rdata, 32'h1122_3344); end
      cycle(1'b1, 4'h0, 32'h0000_0100, 32'h0);
      checks++; if (data_sram_rdata !== 32'h1122_aa44) begin errors++; $display("FAIL ram_byte_merge: got %h want %h", data_sram_rdata, 32'h1122_aa44); end
   endtask

   task automatic test_read_first;
      cycle(1'b1, 4'hf, 32'h0000_0200, 32'h5);
      cycle(1'b1, 4'hf, 32'h0000_0200, 32'h9);
      checks++; if (data_sram_rdata !== 32'h5) begin errors++; $display("FAIL read_first_old: got %h want %h", data_sram_rdata, 32'h5); end
      cycle(1'b1, 4'h0, 32'h0000_0200, 32'h0);
      checks++; if (data_sram_rdata !== 32'h9) begin errors++; $display("FAIL read_after_write: got %h want %h", data_sram_rdata, 32'h9); end
      cycle(1'b0, 4'h0, 32'h0000_0100, 32'hffff_ffff);
      cycle(1'b0, 4'hf, 32'h0000_0100, 32'hffff_ffff);
      checks++; if (data_sram_rdata !== 32'h9) begin errors++; $display("FAIL rdata_hold: got %h want %h", data_sram_rdata, 32'h9); end
      cycle(1'b1, 4'h0, 32'h0001_0200, 32'h0);
      checks++; if (data_sram_rdata !== 32'h9) begin errors++; $display("FAIL ram_alias: got %h want %h", data_sram_rdata, 32'h9); end
      cycle(1'b1, 4'h0, 32'h0000_0100, 32'h0);
      checks++; if (data_sram_rdata !== 32'h1122_aa44) begin errors++; $display("FAIL ram_hold_no_en_write: got %h want %h", data_sram_rdata, 32'h1122_aa44); end
   endtask

   task automatic test_confreg;
      cycle(1'b1, 4'hf, A_LED, 32'h0001_abcd);
      checks++; if (led !== 16'habcd) begin errors++; $display("FAIL led_out: got %h want %h", led, 16'habcd); end
      cycle(1'b1, 4'hf, A_NUM, 32'hdead_beef);
      checks++; if (num_data !== 32'hdead_beef) begin errors++; $display("FAIL num_out: got %h want %h", num_data, 32'hdead_beef); end
      cycle(1'b1, 4'h0, A_LED, 32'h0);
      checks++; if (data_sram_rdata !== 32'h0000_abcd) begin errors++; $display("FAIL led_read: got %h want %h", data_sram_rdata, 32'h0000_abcd); end
      cycle(1'b1, 4'h0, A_UNMAP, 32'h0);
      checks++; if (data_sram_rdata !== 32'h0) begin errors++; $display("FAIL unmapped_read: got %h want %h", data_sram_rdata, 32'h0); end
      cycle(1'b1, 4'b1000, A_NUM, 32'h1200_0000);
      checks++; if (data_sram_rdata !== 32'hdead_beef) begin errors++; $display("FAIL num_prewrite: got %h want %h", data_sram_rdata, 32'hdead_beef); end
      checks++; if (num_data !== 32'h12ad_beef) begin errors++; $display("FAIL num_byte: got %h want %h", num_data, 32'h12ad_beef); end
      cycle(1'b1, 4'hf, A_SCRATCH, 32'h0bad_f00d);
      cycle(1'b1, 4'h0, A_SCRATCH, 32'h0);
      checks++; if (data_sram_rdata !== 32'h0bad_f00d) begin errors++; $display("FAIL scratch_read: got %h want %h", data_sram_rdata, 32'h0bad_f00d); end
   endtask

   task automatic test_switch;
      switch = 8'h5a;
      cycle(1'b0, 4'h0, 32'h0, 32'h0);
      cycle(1'b0, 4'h0, 32'h0, 32'h0);
      cycle(1'b1, 4'h0, A_SWITCH, 32'h0);
      checks++; if (data_sram_rdata !== 32'h0000_005a) begin errors++; $display("FAIL switch_5a: got %h want %h", data_sram_rdata, 32'h0000_005a); end
      switch = 8'hc3;
      cycle(1'b1, 4'h0, A_SWITCH, 32'h0);
      checks++; if (data_sram_rdata !== 32'h0000_005a) begin errors++; $display("FAIL switch_sync_0: got %h want %h", data_sram_rdata, 32'h0000_005a); end
      cycle(1'b1, 4'h0, A_SWITCH, 32'h0);
      checks++; if (data_sram_rdata !== 32'h0000_005a) begin errors++; $display("FAIL switch_sync_1: got %h want %h", data_sram_rdata, 32'h0000_005a); end
      cycle(1'b1, 4'h0, A_SWITCH, 32'h0);
      checks++; if (data_sram_rdata !== 32'h0000_00c3) begin errors++; $display("FAIL switch_sync_2: got %h want %h", data_sram_rdata, 32'h0000_00c3); end
      cycle(1'b1, 4'hf, A_SWITCH, 32'hffff_ffff);
      cycle(1'b1, 4'h0, A_SWITCH, 32'h0);
      checks++; if (data_sram_rdata !== 32'h0000_00c3) begin errors++; $display("FAIL switch_ro: got %h want %h", data_sram_rdata, 32'h0000_00c3); end
   endtask

   task automatic test_timer;
      cycle(1'b1, 4'hf, A_TIMER, 32'hffff_fffe);
`ifdef CONFREG_TIMER_EN
      cycle(1'b1, 4'h0, A_TIMER, 32'h0);
      checks++; if (data_sram_rdata !== 32'hffff_fffe) begin errors++; $display("FAIL timer_load: got %h want %h", data_sram_rdata, 32'hffff_fffe); end
      cycle(1'b1, 4'h0, A_TIMER, 32'h0);
      checks++; if (data_sram_rdata !== 32'hffff_ffff) begin errors++; $display("FAIL timer_inc: got %h want %h", data_sram_rdata, 32'hffff_ffff); end
      cycle(1'b1, 4'h0, A_TIMER, 32'h0);
      checks++; if (data_sram_rdata !== 32'h0) begin errors++; $display("FAIL timer_wrap: got %h want %h", data_sram_rdata, 32'h0); end
`else
      cycle(1'b1, 4'h0, A_SCRATCH, 32'h0);
      cycle(1'b1, 4'h0, A_TIMER, 32'h0);
      checks++; if (data_sram_rdata !== 32'h0) begin errors++; $display("FAIL timer_absent: got %h want %h", data_sram_rdata, 32'h0); end
`endif
   endtask

   task automatic test_back_to_back;
      cycle(1'b1, 4'hf, 32'h0000_0300, 32'hcafe_0001);
      cycle(1'b1, 4'h0, 32'h0000_0300, 32'h0);
      checks++; if (data_sram_rdata !== 32'hcafe_0001) begin errors++; $display("FAIL b2b_ram: got %h want %h", data_sram_rdata, 32'hcafe_0001); end
      cycle(1'b1, 4'h0, A_LED, 32'h0);
      checks++; if (data_sram_rdata !== 32'h0000_abcd) begin errors++; $display("FAIL b2b_conf: got %h want %h", data_sram_rdata, 32'h0000_abcd); end
      cycle(1'b1, 4'h0, 32'h0000_0100, 32'h0);
      checks++; if (data_sram_rdata !== 32'h1122_aa44) begin errors++; $display("FAIL b2b_ram2: got %h want %h", data_sram_rdata, 32'h1122_aa44); end
   endtask

   task automatic test_async_reset;
      cycle(1'b1, 4'hf, A_LED, 32'h0000_1234);
      cycle(1'b1, 4'hf, A_NUM, 32'h5555_aaaa);
      cycle(1'b1, 4'h0, A_NUM, 32'h0);
      checks++; if (data_sram_rdata !== 32'h5555_aaaa) begin errors++; $display("FAIL pre_reset_rdata: got %h want %h", data_sram_rdata, 32'h5555_aaaa); end
      #2 resetn = 1'b0;
      #1;
      checks++; if (led !== 16'h0) begin errors++; $display("FAIL async_led: got %h want %h", led, 16'h0); end
      checks++; if (num_data !== 32'h0) begin errors++; $display("FAIL async_num: got %h want %h", num_data, 32'h0); end
      checks++; if (data_sram_rdata !== 32'h0) begin errors++; $display("FAIL async_rdata: got %h want %h", data_sram_rdata, 32'h0); end
      #1 resetn = 1'b1;
      cycle(1'b1, 4'h0, A_SCRATCH, 32'h0);
      checks++; if (data_sram_rdata !== 32'h0) begin errors++; $display("FAIL post_reset_scratch: got %h want %h", data_sram_rdata, 32'h0); end
      cycle(1'b1, 4'h0, A_SWITCH, 32'h0);
      checks++; if (data_sram_rdata !== 32'h0) begin errors++; $display("FAIL post_reset_switch: got %h want %h", data_sram_rdata, 32'h0); end
      cycle(1'b1, 4'h0, 32'h0000_0300, 32'h0);
      checks++; if (data_sram_rdata !== 32'hcafe_0001) begin errors++; $display("FAIL post_reset_ram: got %h want %h", data_sram_rdata, 32'hcafe_0001); end
   endtask

   initial begin
      resetn          = 1'b0;
      data_sram_en    = 1'b0;
      data_sram_wen   = 4'h0;
      data_sram_addr  = 32'h0;
      data_sram_wdata = 32'h0;
      switch          = 8'h0;
      test_reset();
      test_ram_bytes();
      test_read_first();
      test_confreg();
      test_switch();
      test_timer();
      test_back_to_back();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
